spi_master: RTL and testbench

//  Bring-up sequencer for the test setup: on a push request it pulses a target reset,

---
 rtl/spi_master.sv | 157 +++++++++++++++
 tb/tb_spi_master.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
`timescale 1ns/1ps
// Bring-up sequencer: target reset pulse, write-only SPI payload (mode 0, MSB first), start pulse, fetch/done.
// Latency: done rises RESET_CYCLES+NUM_WORDS*WORD_WIDTH*2*CLK_DIV+3 edges after the edge that samples push.
// Backpressure: none; push is a level request honoured in IDLE, and holding it keeps the block in DONE.
module spi_master #(
    parameter int          CLK_DIV      = 2,
    parameter int          WORD_WIDTH   = 32,
    parameter int          NUM_WORDS    = 4,
    parameter int          RESET_CYCLES = 8,
    parameter logic [31:0] PAYLOAD_BASE = 32'hC0DE_0000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push,
    output logic start,
    output logic done,
    output logic reset,
    output logic fetch,
    output logic spi_sclk,
    output logic spi_sdo,
    output logic spi_cs
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_START,
        S_DONE
    } state_t;

    localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int DW = (CLK_DIV > 1)      ? $clog2(CLK_DIV)      : 1;
    localparam int BW = (WORD_WIDTH > 1)   ? $clog2(WORD_WIDTH)   : 1;
    localparam int NW = (NUM_WORDS > 1)    ? $clog2(NUM_WORDS)    : 1;

    localparam logic [RW-1:0] RST_LAST  = RW'(RESET_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_WIDTH - 1);
    localparam logic [NW-1:0] WORD_LAST = NW'(NUM_WORDS - 1);

    // Word 0 of the payload; later words are derived by adding the word index.
    localparam logic [WORD_WIDTH-1:0] WORD0 = WORD_WIDTH'(PAYLOAD_BASE);

    state_t                state;
    logic [RW-1:0]         rst_cnt;
    logic [DW-1:0]         div_cnt;
    logic [BW-1:0]         bit_idx;
    logic [NW-1:0]         word_idx;
    // Bits of the current word still to be sent after the one on spi_sdo, MSB aligned.
    logic [WORD_WIDTH-2:0] rest;
    logic [WORD_WIDTH-1:0] next_word;

    // Payload word that follows the one currently being shifted out.
    always_comb begin
        next_word = WORD0 + WORD_WIDTH'(word_idx) + WORD_WIDTH'(1);
    end

    // Sequencer FSM; every output is a register so cs/sclk cannot glitch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= S_IDLE;
            start    <= 1'b0;
            done     <= 1'b0;
            reset    <= 1'b0;
            fetch    <= 1'b0;
            spi_sclk <= 1'b0;
            spi_sdo  <= 1'b0;
            spi_cs   <= 1'b1;
            rst_cnt  <= '0;
            div_cnt  <= '0;
            bit_idx  <= '0;
            word_idx <= '0;
            rest     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (push) begin
                        state   <= S_RST;
                        reset   <= 1'b1;
                        rst_cnt <= '0;
                    end
                end
                S_RST: begin
                    if (rst_cnt == RST_LAST) begin
                        // Open the frame with the first data bit already on the line.
                        state    <= S_SETUP;
                        reset    <= 1'b0;
                        spi_cs   <= 1'b0;
                        spi_sdo  <= WORD0[WORD_WIDTH-1];
                        rest     <= WORD0[WORD_WIDTH-2:0];
                        div_cnt  <= '0;
                        bit_idx  <= '0;
                        word_idx <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                S_SETUP: begin
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!spi_sclk) begin
                            spi_sclk <= 1'b1;
                        end else begin
                            // Falling edge closes a bit; sdo moves only here.
                            spi_sclk <= 1'b0;
                            if (bit_idx == BIT_LAST) begin
                                bit_idx <= '0;
                                if (word_idx == WORD_LAST) begin
                                    state <= S_HOLD;
                                end else begin
                                    word_idx <= word_idx + 1'b1;
                                    spi_sdo  <= next_word[WORD_WIDTH-1];
                                    rest     <= next_word[WORD_WIDTH-2:0];
                                end
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                                spi_sdo <= rest[WORD_WIDTH-2];
                                rest    <= rest << 1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    state   <= S_START;
                    start   <= 1'b1;
                    spi_cs  <= 1'b1;
                    spi_sdo <= 1'b0;
                end
                S_START: begin
                    state <= S_DONE;
                    start <= 1'b0;
                    done  <= 1'b1;
                    fetch <= 1'b1;
                end
                S_DONE: begin
                    if (!push) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                        fetch <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
`timescale 1ns/1ps
// Randomised bench for spi_master: stimulus queues expected edges and words, a monitor checks them.
// Expected timing comes from the phase lengths of the sequence; payload words from base+index.
// The bench never stalls the DUT; push timing, idle gaps and DONE dwell are randomised.
module tb_spi_master;

    localparam int          CLK_DIV   = 2;
    localparam int          WW        = 32;
    localparam int          NWORDS    = 4;
    localparam int          RCYC      = 8;
    localparam logic [31:0] BASE      = 32'hC0DE_0000;
    localparam int          NBITS     = NWORDS * WW;
    localparam int          SHIFT_CYC = NBITS * 2 * CLK_DIV;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic push = 1'b0;
    logic start, done, reset, fetch, spi_sclk, spi_sdo, spi_cs;

    spi_master #(
        .CLK_DIV      (CLK_DIV),
        .WORD_WIDTH   (WW),
        .NUM_WORDS    (NWORDS),
        .RESET_CYCLES (RCYC),
        .PAYLOAD_BASE (BASE)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .push     (push),
        .start    (start),
        .done     (done),
        .reset    (reset),
        .fetch    (fetch),
        .spi_sclk (spi_sclk),
        .spi_sdo  (spi_sdo),
        .spi_cs   (spi_cs)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected output transitions: kind and the cycle count at which the monitor should see them.
    typedef struct {
        int kind;
        int at;
    } ev_t;

    ev_t           exp_ev[$];
    logic [WW-1:0] exp_word[$];

    function automatic string kname(input int k);
        case (k)
            0: return "reset_rise";
            1: return "reset_fall";
            2: return "cs_fall";
            3: return "cs_rise";
            4: return "start_rise";
            5: return "start_fall";
            6: return "done_rise";
            7: return "done_fall";
            8: return "fetch_rise";
            default: return "fetch_fall";
        endcase
    endfunction

    task automatic expect_ev(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        exp_ev.push_back(e);
    endtask

    task automatic match_ev(input int kind);
        int idx = -1;
        for (int i = 0; i < exp_ev.size(); i++) begin
            if (idx < 0 && exp_ev[i].kind == kind) idx = i;
        end
        if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected %s actual cycle %0d required none", kname(kind), cyc);
        end else begin
            chk(kname(kind), 64'(cyc), 64'(exp_ev[idx].at));
            exp_ev.delete(idx);
        end
    endtask

    // Monitor state
    logic          p_reset, p_cs, p_start, p_done, p_fetch, p_sclk, p_sdo;
    int            nrise, viol, idle_viol, last_tog, cs_fall_at, bitcnt;
    int            done_rises = 0;
    logic [WW-1:0] acc;

    initial begin
        idle_viol = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_reset = 1'b0; p_cs = 1'b1; p_start = 1'b0; p_done = 1'b0;
                p_fetch = 1'b0; p_sclk = 1'b0; p_sdo = 1'b0;
                nrise = 0; viol = 0; bitcnt = 0; last_tog = 0; cs_fall_at = 0; acc = '0;
            end else begin
                if (reset !== p_reset) match_ev(reset ? 0 : 1);
                if (spi_cs !== p_cs) begin
                    match_ev(spi_cs ? 3 : 2);
                    if (!spi_cs) begin
                        cs_fall_at = cyc;
                        nrise = 0;
                        viol = 0;
                        bitcnt = 0;
                    end else begin
                        chk("sclk_rises", 64'(nrise), 64'(NBITS));
                        chk("sclk_sdo_violations", 64'(viol), 64'd0);
                    end
                end
                if (start !== p_start) match_ev(start ? 4 : 5);
                if (done !== p_done) begin
                    match_ev(done ? 6 : 7);
                    if (done) done_rises++;
                end
                if (fetch !== p_fetch) match_ev(fetch ? 8 : 9);
                if (spi_sclk !== p_sclk) begin
                    if (spi_cs) idle_viol++;
                    if (spi_sclk) begin
                        if (nrise == 0) begin
                            if (cyc != cs_fall_at + 1 + CLK_DIV) viol++;
                        end else if (cyc - last_tog != CLK_DIV) begin
                            viol++;
                        end
                        nrise++;
                        acc = {acc[WW-2:0], spi_sdo};
                        bitcnt++;
                        if (bitcnt == WW) begin
                            bitcnt = 0;
                            if (exp_word.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL unexpected_word actual 0x%0h required none", acc);
                            end else begin
                                chk("word", 64'(acc), 64'(exp_word.pop_front()));
                            end
                        end
                    end else if (cyc - last_tog != CLK_DIV) begin
                        viol++;
                    end
                    last_tog = cyc;
                end
                // sdo may only move together with a falling sclk, never while sclk is high.
                if (spi_sdo !== p_sdo && spi_sclk) viol++;
                p_reset = reset; p_cs = spi_cs; p_start = start; p_done = done;
                p_fetch = fetch; p_sclk = spi_sclk; p_sdo = spi_sdo;
            end
        end
    end

    // One full bring-up: optional push noise while busy, random dwell in DONE, then release.
    task automatic run_seq(input bit wiggle, input int dwell, input int gap);
        int e1, st, dn;
        repeat (gap) @(negedge clk);
        push = 1'b1;
        e1 = cyc + 1;
        st = e1 + RCYC + 1 + SHIFT_CYC + 1;
        dn = st + 1;
        expect_ev(0, e1);
        expect_ev(1, e1 + RCYC);
        expect_ev(2, e1 + RCYC);
        expect_ev(4, st);
        expect_ev(3, st);
        expect_ev(5, dn);
        expect_ev(6, dn);
        expect_ev(8, dn);
        for (int w = 0; w < NWORDS; w++) exp_word.push_back(WW'(BASE + 32'(w)));
        while (cyc < dn + dwell - 1) begin
            @(negedge clk);
            if (wiggle && cyc < st - 4) push = 1'($urandom_range(0, 1));
            else push = 1'b1;
        end
        push = 1'b0;
        expect_ev(7, cyc + 1);
        expect_ev(9, cyc + 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual timeout required completion");
        $fatal(1);
    end

    initial begin
        int e1;
        rst_n = 1'b0;
        push  = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({spi_cs, spi_sclk, spi_sdo, start, done, reset, fetch}), 64'b1000000);
        push  = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        run_seq(1'b0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            run_seq(i == 1, int'($urandom_range(1, 20)), int'($urandom_range(0, 15)));
        end

        // Abort partway through the shift phase: word 0 completes, the rest must never appear.
        repeat (int'($urandom_range(1, 10))) @(negedge clk);
        push = 1'b1;
        e1 = cyc + 1;
        expect_ev(0, e1);
        expect_ev(1, e1 + RCYC);
        expect_ev(2, e1 + RCYC);
        exp_word.push_back(WW'(BASE));
        while (cyc < e1 + RCYC + 1 + 40 * 2 * CLK_DIV + 1) begin
            @(negedge clk);
            push = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", 64'({spi_cs, spi_sclk, spi_sdo, start, done, reset, fetch}), 64'b1000000);
        chk("abort_pending_events", 64'(exp_ev.size()), 64'd0);
        chk("abort_pending_words", 64'(exp_word.size()), 64'd0);
        exp_ev.delete();
        exp_word.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (600) @(negedge clk);

        run_seq(1'b1, int'($urandom_range(1, 20)), int'($urandom_range(0, 15)));

        repeat (5) @(negedge clk);
        chk("pending_events", 64'(exp_ev.size()), 64'd0);
        chk("pending_words", 64'(exp_word.size()), 64'd0);
        chk("done_rises", 64'(done_rises), 64'd5);
        chk("sclk_idle_toggles", 64'(idle_viol), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
